// File: rtl/vram_span_writer.sv
// Horizontal span writer for the 320x200 4bpp packed Video RAM (2 pixels/byte).
// Whole bytes are written directly; edge nibbles get a fresh read-modify-write.
module vram_span_writer #(
  parameter int READ_LATENCY = 1,
  parameter int LINE_BYTES   = 160,
  parameter int MAX_X        = 319,
  parameter int MAX_Y        = 199
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_y,
  input  logic [8:0]  req_x0,
  input  logic [8:0]  req_x1,
  input  logic [3:0]  req_color,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [14:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  input  logic [7:0]  vram_rdata
);

  localparam logic [8:0] MAX_X9 = 9'(MAX_X);
  localparam logic [7:0] MAX_Y8 = 8'(MAX_Y);
  localparam logic [1:0] RD_LAST = 2'(READ_LATENCY);

  typedef enum logic [2:0] {IDLE, FULL, RD, MERGE, FIN} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  y_reg, y_next;
  logic [8:0]  x1_reg, x1_next;
  logic [8:0]  cur_x_reg, cur_x_next;
  logic [3:0]  color_reg, color_next;
  logic [1:0]  rd_cnt_reg, rd_cnt_next;
  logic [7:0]  rd_data_reg, rd_data_next;
  logic        err_reg, err_next;
  logic [14:0] byte_addr;
  logic [8:0]  x1_clip;

  // Decides what the byte holding pixel cx needs: nothing left, a whole byte, or an RMW.
  function automatic state_t issue(input logic [8:0] cx, input logic [8:0] last);
    if (cx > last)
      return FIN;
    else if (!cx[0] && (cx + 9'd1 <= last))
      return FULL;
    else
      return RD;
  endfunction

  assign byte_addr = 15'(y_reg) * 15'(LINE_BYTES) + {6'd0, cur_x_reg[8:1]};
  assign x1_clip   = (req_x1 > MAX_X9) ? MAX_X9 : req_x1;
  assign busy      = (state_reg != IDLE);
  assign req_ready = !busy;
  assign done      = (state_reg == FIN);
  assign err       = err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      y_reg       <= '0;
      x1_reg      <= '0;
      cur_x_reg   <= '0;
      color_reg   <= '0;
      rd_cnt_reg  <= '0;
      rd_data_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      y_reg       <= y_next;
      x1_reg      <= x1_next;
      cur_x_reg   <= cur_x_next;
      color_reg   <= color_next;
      rd_cnt_reg  <= rd_cnt_next;
      rd_data_reg <= rd_data_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    y_next       = y_reg;
    x1_next      = x1_reg;
    cur_x_next   = cur_x_reg;
    color_next   = color_reg;
    rd_cnt_next  = rd_cnt_reg;
    rd_data_next = rd_data_reg;
    err_next     = 1'b0;
    vram_we      = 1'b0;
    vram_addr    = '0;
    vram_wdata   = '0;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if ((req_x0 > MAX_X9) || (req_y > MAX_Y8) || (req_x0 > req_x1)) begin
            err_next = 1'b1;
          end else begin
            y_next      = req_y;
            x1_next     = x1_clip;
            color_next  = req_color;
            cur_x_next  = req_x0;
            rd_cnt_next = '0;
            state_next  = issue(req_x0, x1_clip);
          end
        end
      end
      FULL: begin
        vram_we    = 1'b1;
        vram_addr  = byte_addr;
        vram_wdata = {color_reg, color_reg};
        cur_x_next = cur_x_reg + 9'd2;
        state_next = issue(cur_x_reg + 9'd2, x1_reg);
      end
      RD: begin
        // Address stays on the bus for the whole wait so the RAM sees a steady read.
        vram_addr   = byte_addr;
        rd_cnt_next = rd_cnt_reg + 2'd1;
        if (rd_cnt_reg == RD_LAST) begin
          rd_data_next = vram_rdata;
          rd_cnt_next  = '0;
          state_next   = MERGE;
        end
      end
      MERGE: begin
        vram_we    = 1'b1;
        vram_addr  = byte_addr;
        vram_wdata = cur_x_reg[0] ? {rd_data_reg[7:4], color_reg}
                                  : {color_reg, rd_data_reg[3:0]};
        cur_x_next = cur_x_reg + 9'd1;
        state_next = issue(cur_x_reg + 9'd1, x1_reg);
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_vram_span_writer.sv
// Directed bench for vram_span_writer against a 1-cycle-latency byte RAM model.
module tb_vram_span_writer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_y = '0;
  logic [8:0]  req_x0 = '0;
  logic [8:0]  req_x1 = '0;
  logic [3:0]  req_color = '0;
  logic        busy, done, err;
  logic [14:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic [7:0]  vram_rdata;

  logic [7:0]  mem [0:32767];
  logic        poke_en = 1'b0;
  logic [14:0] poke_addr = '0;
  logic [7:0]  poke_data = '0;
  int          wr_cnt = 0;
  logic [14:0] wa [0:511];
  logic [7:0]  wd [0:511];

  int tests = 0;
  int fails = 0;
  int base, cyc, n, w;

  always #5 clk = ~clk;

  vram_span_writer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_y(req_y), .req_x0(req_x0), .req_x1(req_x1), .req_color(req_color),
    .busy(busy), .done(done), .err(err),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we),
    .vram_rdata(vram_rdata)
  );

  // RAM model with registered read; also logs every write for later checking.
  always @(posedge clk) begin
    vram_rdata <= mem[vram_addr];
    if (vram_we) begin
      mem[vram_addr] <= vram_wdata;
      if (wr_cnt < 512) begin
        wa[wr_cnt] <= vram_addr;
        wd[wr_cnt] <= vram_wdata;
      end
      wr_cnt <= wr_cnt + 1;
    end else if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [14:0] a, input logic [7:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic send(input logic [7:0] y, input logic [8:0] x0, input logic [8:0] x1,
                      input logic [3:0] c);
    int k;
    @(negedge clk);
    req_y = y; req_x0 = x0; req_x1 = x1; req_color = c; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("accept_ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done && c < 400);
    chk("done_seen", done, 1);
  endtask

  task automatic reject(input string tag, input logic [7:0] y, input logic [8:0] x0,
                        input logic [8:0] x1);
    int b;
    b = wr_cnt;
    send(y, x0, x1, 4'h1);
    @(negedge clk);
    chk({tag, "_err"}, err, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, req_ready, 1);
    @(negedge clk);
    chk({tag, "_err_pulse"}, err, 0);
    chk({tag, "_no_we"}, wr_cnt - b, 0);
    $display("[TB] reject %s y=%0d x0=%0d x1=%0d", tag, y, x0, x1);
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_we", vram_we, 0);
    chk("rst_addr", vram_addr, 0);
    chk("rst_wdata", vram_wdata, 0);
    chk("rst_ready", req_ready, 1);
    rst_n = 1'b1;

    // Single even pixel: RMW of byte 0
    poke(15'd0, 8'hAB);
    base = wr_cnt;
    send(8'd0, 9'd0, 9'd0, 4'h5);
    wait_done(cyc);
    chk("plot0_cycles", cyc, 4);
    chk("plot0_nwr", wr_cnt - base, 1);
    chk("plot0_addr", wa[base], 0);
    chk("plot0_data", wd[base], 8'h5B);
    @(negedge clk);
    chk("plot0_done_pulse", done, 0);
    $display("[TB] plot y=0 x=0 c=5 -> 0x%0h after %0d cycles", wd[base], cyc);

    // Last pixel of the screen
    poke(15'd31999, 8'h12);
    base = wr_cnt;
    send(8'd199, 9'd319, 9'd319, 4'hC);
    wait_done(cyc);
    chk("plotlast_nwr", wr_cnt - base, 1);
    chk("plotlast_addr", wa[base], 31999);
    chk("plotlast_data", wd[base], 8'h1C);
    $display("[TB] plot y=199 x=319 c=C -> 0x%0h", wd[base]);

    // Span with partial bytes on both ends
    for (int i = 0; i < 4; i++) poke(15'(160 + i), 8'h00);
    base = wr_cnt;
    send(8'd1, 9'd1, 9'd6, 4'hF);
    wait_done(cyc);
    chk("span_cycles", cyc, 9);
    chk("span_nwr", wr_cnt - base, 4);
    chk("span_a0", wa[base], 160);
    chk("span_d0", wd[base], 8'h0F);
    chk("span_a1", wa[base+1], 161);
    chk("span_d1", wd[base+1], 8'hFF);
    chk("span_a2", wa[base+2], 162);
    chk("span_d2", wd[base+2], 8'hFF);
    chk("span_a3", wa[base+3], 163);
    chk("span_d3", wd[base+3], 8'hF0);
    $display("[TB] span y=1 x=1..6 c=F: %0d writes", wr_cnt - base);

    // Full byte: write appears one cycle after acceptance
    send(8'd4, 9'd0, 9'd1, 4'h6);
    @(negedge clk);
    chk("lat_we", vram_we, 1);
    chk("lat_addr", vram_addr, 640);
    chk("lat_wdata", vram_wdata, 8'h66);
    @(negedge clk);
    chk("lat_done", done, 1);
    $display("[TB] full byte y=4 x=0..1 c=6 written at addr %0d", wa[wr_cnt-1]);

    // Rejected requests
    reject("x0_oob", 8'd0, 9'd320, 9'd320);
    reject("x0_gt_x1", 8'd0, 9'd10, 9'd5);
    reject("y_oob", 8'd200, 9'd0, 9'd0);

    // x1 clipped to the right edge
    base = wr_cnt;
    send(8'd5, 9'd318, 9'd400, 4'h9);
    wait_done(cyc);
    chk("clip_cycles", cyc, 2);
    chk("clip_nwr", wr_cnt - base, 1);
    chk("clip_addr", wa[base], 959);
    chk("clip_data", wd[base], 8'h99);
    $display("[TB] clipped span y=5 x=318..400 -> addr %0d", wa[base]);

    // Back-to-back: second request held while busy
    base = wr_cnt;
    send(8'd3, 9'd0, 9'd3, 4'h1);
    @(negedge clk);
    req_y = 8'd3; req_x0 = 9'd4; req_x1 = 9'd5; req_color = 4'h2; req_valid = 1'b1;
    chk("b2b_ready_busy", req_ready, 0);
    cyc = 1;
    while (!done && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_first_cycles", cyc, 3);
    chk("b2b_ready_at_done", req_ready, 0);
    @(negedge clk);
    chk("b2b_ready_after", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_done(cyc);
    chk("b2b_second_cycles", cyc, 2);
    chk("b2b_nwr", wr_cnt - base, 3);
    chk("b2b_a0", wa[base], 480);
    chk("b2b_a1", wa[base+1], 481);
    chk("b2b_a2", wa[base+2], 482);
    chk("b2b_d1", wd[base+1], 8'h11);
    chk("b2b_d2", wd[base+2], 8'h22);
    $display("[TB] back-to-back y=3: %0d writes", wr_cnt - base);

    // Full-width span: only whole-byte writes
    base = wr_cnt;
    send(8'd7, 9'd0, 9'd319, 4'h2);
    wait_done(cyc);
    chk("fw_cycles", cyc, 161);
    chk("fw_nwr", wr_cnt - base, 160);
    chk("fw_first", wa[base], 1120);
    chk("fw_last", wa[base+159], 1279);
    chk("fw_data", wd[base+159], 8'h22);
    $display("[TB] full-width y=7: %0d writes in %0d cycles", wr_cnt - base, cyc);

    // Reset in the middle of a full-width span
    base = wr_cnt;
    send(8'd6, 9'd0, 9'd319, 4'hA);
    n = 0;
    while ((wr_cnt - base) < 50 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached", wr_cnt - base, 50);
    rst_n = 1'b0;
    #1;
    chk("mid_we", vram_we, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    w = wr_cnt;
    repeat (3) @(negedge clk);
    chk("mid_no_more_wr", wr_cnt - w, 0);
    rst_n = 1'b1;
    #1;
    chk("mid_ready", req_ready, 1);
    $display("[TB] reset mid-span after %0d writes", wr_cnt - base);

    poke(15'd325, 8'h77);
    base = wr_cnt;
    send(8'd2, 9'd11, 9'd11, 4'h3);
    wait_done(cyc);
    chk("post_cycles", cyc, 4);
    chk("post_nwr", wr_cnt - base, 1);
    chk("post_addr", wa[base], 325);
    chk("post_data", wd[base], 8'h73);
    $display("[TB] plot after reset y=2 x=11 c=3 -> 0x%0h", wd[base]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
